// File: rtl/mem_responder.sv
// CPU memory-bus responder: word RAM plus an I/O window holding an output FIFO,
// an input mailbox and a free-running cycle counter. All reads are combinational.
module mem_responder #(
  parameter int unsigned RAM_AW  = 14,
  parameter int unsigned FIFO_AW = 3,
  parameter logic [14:0] IO_BASE = 15'h7FF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [14:0] mem_addr,
  input  logic [15:0] mem_in,
  output logic [15:0] mem_out,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 15;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned RAM_WORDS = 2 ** RAM_AW;

  logic [DW-1:0]      ram      [RAM_WORDS];
  logic [DW-1:0]      fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic               overflow;
  logic               mailbox_full;
  logic [DW-1:0]      mailbox_data;
  logic [DW-1:0]      hi_latch;
  logic [31:0]        counter;

  logic          is_io_c;
  logic          in_win_c;
  logic [AW-1:0] io_off_c;
  logic [3:0]    off_c;
  logic          wr_out_c, wr_stat_c, wr_lo_c, wr_ack_c;
  logic          fifo_full_c, pop_c, push_ok_c, ovf_set_c, capture_c;
  logic [DW-1:0] status_c;

  // Address decode and write strobes for the I/O window
  always_comb begin
    is_io_c   = (mem_addr >= IO_BASE);
    io_off_c  = mem_addr - IO_BASE;
    in_win_c  = is_io_c && (io_off_c < AW'(16));
    off_c     = io_off_c[3:0];
    wr_out_c  = mem_we && in_win_c && (off_c == 4'd0);
    wr_stat_c = mem_we && in_win_c && (off_c == 4'd1);
    wr_lo_c   = mem_we && in_win_c && (off_c == 4'd2);
    wr_ack_c  = mem_we && in_win_c && (off_c == 4'd4);
  end

  assign out_valid   = (count != '0);
  assign out_data    = fifo_mem[rd_ptr];
  assign in_ready    = !mailbox_full;
  assign fifo_full_c = (count == CW'(DEPTH));
  assign pop_c       = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok_c   = wr_out_c && (!fifo_full_c || pop_c);
  assign ovf_set_c   = wr_out_c && fifo_full_c && !pop_c;
  assign capture_c   = in_valid && in_ready;
  assign status_c    = {overflow, 6'b0, mailbox_full, 3'b0, fifo_full_c, 4'(count)};

  always_comb begin
    mem_out = '0;
    if (!is_io_c) begin
      mem_out = ram[mem_addr[RAM_AW-1:0]];
    end else if (in_win_c) begin
      case (off_c)
        4'd1:    mem_out = status_c;
        4'd2:    mem_out = counter[15:0];
        4'd3:    mem_out = hi_latch;
        4'd4:    mem_out = mailbox_full ? mailbox_data : '0;
        default: mem_out = '0;
      endcase
    end
  end

  // Storage arrays carry no reset; reset only suppresses the write
  always_ff @(posedge clk) begin
    if (rst_n && mem_we && !is_io_c) ram[mem_addr[RAM_AW-1:0]] <= mem_in;
    if (rst_n && push_ok_c) fifo_mem[wr_ptr] <= mem_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      mailbox_full <= 1'b0;
      mailbox_data <= '0;
      hi_latch     <= '0;
      counter      <= '0;
    end else begin
      counter <= counter + 32'd1;
      if (push_ok_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push_ok_c && !pop_c)      count <= count + CW'(1);
      else if (!push_ok_c && pop_c) count <= count - CW'(1);
      // Overflow set takes priority over a same-cycle clear
      if (ovf_set_c)                     overflow <= 1'b1;
      else if (wr_stat_c && mem_in[15])  overflow <= 1'b0;
      if (wr_lo_c) hi_latch <= counter[31:16];
      if (capture_c) begin
        mailbox_full <= 1'b1;
        mailbox_data <= in_data;
      end else if (wr_ack_c) begin
        mailbox_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_in;
  logic [15:0] mem_out;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  int checks   = 0;
  int failures = 0;

  mem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_in    (mem_in),
    .mem_out   (mem_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    mem_addr = a;
    mem_in   = d;
    mem_we   = 1'b1;
    step();
    mem_we   = 1'b0;
  endtask

  task automatic rd(input logic [14:0] a, output logic [15:0] d);
    mem_we   = 1'b0;
    mem_addr = a;
    #1;
    d = mem_out;
  endtask

  logic [15:0] r;

  initial begin
    rst_n = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_in = '0;
    out_ready = 1'b0; in_data = '0; in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rd(15'h7FF1, r); chk("rst_status", 32'(r), 32'h0000);

    // RAM and aliasing
    wr(15'h0005, 16'h1234);
    wr(15'h4005, 16'hBEEF);
    rd(15'h0005, r); chk("ram_alias", 32'(r), 32'hBEEF);
    rd(15'h7FF5, r); chk("io_unused_rd", 32'(r), 32'h0000);
    mem_addr = 15'h0005; mem_in = 16'h7777; mem_we = 1'b1; #1;
    chk("ram_old_before_edge", 32'(mem_out), 32'hBEEF);
    step();
    mem_we = 1'b0; #1;
    chk("ram_new_after_edge", 32'(mem_out), 32'h7777);

    // FIFO overflow then drain
    for (int i = 0; i < 9; i++) wr(15'h7FF0, 16'(16'h00A0 + i));
    rd(15'h7FF1, r); chk("ovf_status", 32'(r), 32'h8018);
    rd(15'h7FF0, r); chk("out_data_reg_rd", 32'(r), 32'h0000);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", 32'(out_data), 32'(16'h00A0 + i));
      step();
    end
    out_ready = 1'b0;
    #1;
    chk("drain_empty", 32'(out_valid), 32'd0);
    rd(15'h7FF1, r); chk("ovf_kept", 32'(r), 32'h8000);
    wr(15'h7FF1, 16'h8000);
    rd(15'h7FF1, r); chk("ovf_clear", 32'(r), 32'h0000);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) wr(15'h7FF0, 16'(16'h00B0 + i));
    out_ready = 1'b1;
    wr(15'h7FF0, 16'h00B8);
    out_ready = 1'b0;
    rd(15'h7FF1, r); chk("full_pushpop_status", 32'(r), 32'h0018);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("pushpop_data", 32'(out_data), 32'(16'h00B1 + i));
      step();
    end
    out_ready = 1'b0;
    #1;
    chk("pushpop_empty", 32'(out_valid), 32'd0);

    // Mailbox capture, then acknowledge colliding with a new offer
    in_data = 16'h55AA; in_valid = 1'b1;
    step();
    in_valid = 1'b0; #1;
    chk("mb_in_ready_full", 32'(in_ready), 32'd0);
    rd(15'h7FF4, r); chk("mb_data", 32'(r), 32'h55AA);
    rd(15'h7FF1, r); chk("mb_status", 32'(r), 32'h0100);
    in_data = 16'h1111; in_valid = 1'b1;
    wr(15'h7FF4, 16'h0000);
    chk("mb_ack_ready", 32'(in_ready), 32'd1);
    rd(15'h7FF4, r); chk("mb_ack_no_capture", 32'(r), 32'h0000);
    step();
    in_valid = 1'b0;
    rd(15'h7FF4, r); chk("mb_capture_next", 32'(r), 32'h1111);

    // Ignored window locations
    wr(15'h7FF7, 16'hFFFF);
    rd(15'h7FF7, r); chk("io_ignored_rd", 32'(r), 32'h0000);

    // Reset mid-stream, overriding a same-cycle push
    for (int i = 0; i < 3; i++) wr(15'h7FF0, 16'(16'h00C0 + i));
    rd(15'h7FF1, r); chk("pre_rst_status", 32'(r), 32'h0103);
    rst_n = 1'b0; mem_addr = 15'h7FF0; mem_in = 16'hDEAD; mem_we = 1'b1;
    step();
    rst_n = 1'b1; mem_we = 1'b0; #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rd(15'h7FF1, r); chk("mid_rst_status", 32'(r), 32'h0000);
    rd(15'h7FF2, r); chk("mid_rst_cnt_lo", 32'(r), 32'h0000);
    rd(15'h7FF3, r); chk("mid_rst_hi", 32'(r), 32'h0000);

    // Cycle counter and high-half latch
    repeat (32'h10005) step();
    rd(15'h7FF3, r); chk("hi_before_latch", 32'(r), 32'h0000);
    wr(15'h7FF2, 16'h0000);
    rd(15'h7FF3, r); chk("hi_latched", 32'(r), 32'h0001);
    rd(15'h7FF2, r); chk("cnt_lo", 32'(r), 32'h0006);
    step();
    rd(15'h7FF2, r); chk("cnt_lo_live", 32'(r), 32'h0007);
    wr(15'h7FF3, 16'hFFFF);
    rd(15'h7FF3, r); chk("hi_write_ignored", 32'(r), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the CPU memory bus: the CPU drives mem_we, mem_addr and mem_in, and this block returns mem_out.
- Contains the word RAM plus a small memory-mapped I/O window at the top of the address space.
- The I/O window holds an 8-deep output FIFO (CPU to outside), a 1-entry input mailbox (outside to CPU) and a 32-bit cycle counter.
- Sits beside the CPU at top level and is wired port-for-port to its memory pins.

Parameters:
- RAM_AW, 14, RAM word-address width; RAM holds 2^RAM_AW 16-bit words.
- FIFO_AW, 3, output FIFO depth is 2^FIFO_AW (8).
- IO_BASE, 15'h7FF0, first word address of the I/O window; the window spans IO_BASE..IO_BASE+15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mem_we  in  1  CPU write strobe; a write commits on the rising edge.
- mem_addr  in  15  CPU word address.
- mem_in  in  16  CPU write data.
- mem_out  out  16  read data, combinational from mem_addr.
- out_data  out  16  output FIFO head word.
- out_valid  out  1  output FIFO non-empty.
- out_ready  in  1  consumer accepts out_data.
- in_data  in  16  external input word.
- in_valid  in  1  external producer offers in_data.
- in_ready  out  1  mailbox empty, can accept a word.

Behaviour:
- One clock, clk. Reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - FIFO count 0, pointers 0, so out_valid=0.
  - mailbox_full=0, so in_ready=1; mailbox data 0.
  - cycle counter 0, hi_latch 0, overflow sticky 0.
  - RAM contents are not reset.
  - Reset overrides every same-cycle push, pop, write or capture.
- No stall exists on the CPU bus, so reads are combinational with zero-cycle latency. No read has side effects; every state change is write-triggered.
- RAM: for mem_addr < IO_BASE, mem_out = ram[mem_addr[RAM_AW-1:0]] (aliasing above 2^RAM_AW). When mem_we=1, ram[...] <= mem_in at the edge. A read of the address being written returns the old word until the edge.
- I/O map, as offset from IO_BASE:
  - +0 OUT_DATA:
    - Write pushes mem_in into the FIFO.
    - If the FIFO is full and no pop occurs that cycle, the word is dropped and overflow is set.
    - Read returns 0.
  - +1 STATUS:
    - Read returns {overflow, 6'b0, mailbox_full, 3'b0, fifo_full, count[3:0]}.
    - A write with mem_in[15]=1 clears overflow. If an overflow event occurs in the same cycle, the set wins.
  - +2 CYCLE_LO:
    - Read returns counter[15:0].
    - Any write copies counter[31:16] into hi_latch; counter is not modified.
  - +3 CYCLE_HI: read returns hi_latch; writes are ignored.
  - +4 IN_DATA:
    - Read returns mailbox data, or 0 if empty.
    - Any write acknowledges: mailbox_full <= 0.
  - +5..+15: read 0, writes ignored.
- Cycle counter: 32-bit, increments every non-reset cycle, wraps 0xFFFFFFFF to 0.
- Output FIFO:
  - out_valid = count!=0; out_data = head word.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are both performed; count is unchanged, including when full.
  - Pointers wrap modulo 2^FIFO_AW.
- Input mailbox:
  - in_ready = !mailbox_full.
  - Capture in_data when in_valid && in_ready, setting mailbox_full.
  - If a CPU acknowledge and an external offer land in the same cycle, the acknowledge clears and in_ready is still 0 that cycle, so there is no capture. The capture happens next cycle at the earliest.
- Accesses at or above IO_BASE never touch RAM.

Test Plan:
- Reset, then write 0x1234 to 0x0005 and 0xBEEF to 0x4005 (RAM_AW=14 alias) -> reading 0x0005 returns 0xBEEF; reading 0x7FF5 returns 0; out_valid=0, in_ready=1 after reset.
- Write 0xA0..0xA8 (9 words) to 0x7FF0 with out_ready=0 -> STATUS=0x8018 (overflow, full, count 8); raise out_ready -> out_data sequence 0xA0..0xA7, then out_valid=0; write 0x8000 to STATUS -> overflow clear.
- FIFO full with out_ready=1 plus a push in the same cycle -> count stays 8, new word is stored, overflow stays 0.
- in_valid=1, in_data=0x55AA -> captured next edge, in_ready=0, read 0x7FF4 = 0x55AA, STATUS bit8=1; write 0x7FF4 -> in_ready=1 the following cycle, read 0x7FF4 = 0.
- Run 0x10005 cycles after reset, write 0x7FF2 -> read 0x7FF3 = 0x0001; 0x7FF2 read tracks the live counter low half.
- Assert rst_n=0 mid-stream with the FIFO holding 3 words and the mailbox full -> next cycle out_valid=0, in_ready=1, STATUS=0x0000, counter=0.
